// File: rtl/dff_chk_pkg.sv
// Shared state encoding, limits and saturating-increment helper for dff_resp_checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        HALT
    } chk_state_t;

    localparam int MAX_LATENCY = 8;
    localparam int MAX_CNT_W   = 32;
    localparam int FILL_CNT_W  = $clog2(MAX_LATENCY);

    // Increment cnt, sticking at the all-ones value of a width-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input int unsigned          width
    );
        logic [MAX_CNT_W-1:0] top;
        top = (width >= MAX_CNT_W) ? '1
                                   : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
        return (cnt >= top) ? cnt : cnt + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/chk_delay_line.sv
// WIDTH x DEPTH shift register that advances only while en_i is high; q_o is the oldest entry.
module chk_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] hist_q;
    logic [DEPTH-1:0][WIDTH-1:0] hist_d;

    always_comb begin
        // NOTE: default first so every path assigns hist_d and no latch is inferred.
        hist_d = hist_q;
        if (en_i) begin
            hist_d[0] = d_i;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the history is cleared on reset because a stale entry must never be
        // compared against the first response after reset; that makes it flops, not RAM.
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign q_o = hist_q[DEPTH-1];

endmodule

// File: rtl/dff_resp_checker.sv
// Checks that resp equals stim delayed by LATENCY clocks; counts compares/mismatches, sticky fail.
// Define DFF_RESP_CHECKER_HALT_EN to freeze in a terminal HALT state on the first mismatch.
module dff_resp_checker
    import dff_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] resp,
    output logic             busy,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("dff_resp_checker: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $error("dff_resp_checker: CNT_W=%0d outside 1..%0d", CNT_W, MAX_CNT_W);
    end

    chk_state_t            state_q, state_d;
    logic [FILL_CNT_W-1:0] fill_q, fill_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic [CNT_W-1:0]      chk_q, chk_d;
    logic [WIDTH-1:0]      expected;
    logic                  fill_done;
    logic                  mismatch;
    logic                  do_compare;

    chk_delay_line #(
        .WIDTH(WIDTH),
        .DEPTH(LATENCY)
    ) u_hist (
        .clk (clk),
        .rst (rst),
        .en_i(en),
        .d_i (stim),
        .q_o (expected)
    );

    assign fill_done = (fill_q == FILL_CNT_W'(LATENCY - 1));
    // Case inequality so an X/Z response in simulation is scored as a mismatch.
    assign mismatch  = (resp !== expected);

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        fail_d     = fail_q;
        err_d      = err_q;
        chk_d      = chk_q;
        do_compare = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            end
            FILL: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (fill_done) begin
                    // The edge that completes the fill already has a valid history entry.
                    state_d    = CHECK;
                    do_compare = 1'b1;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    do_compare = 1'b1;
                end
            end
            HALT: begin
`ifdef DFF_RESP_CHECKER_HALT_EN
                state_d = HALT;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (do_compare) begin
            chk_d = CNT_W'(sat_inc(MAX_CNT_W'(chk_q), CNT_W));
            if (mismatch) begin
                err_d  = CNT_W'(sat_inc(MAX_CNT_W'(err_q), CNT_W));
                fail_d = 1'b1;
`ifdef DFF_RESP_CHECKER_HALT_EN
                state_d = HALT;
`endif
            end
        end

        busy_d = (state_d == FILL) || (state_d == CHECK);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
        end
    end

    assign busy    = busy_q;
    assign fail    = fail_q;
    assign err_cnt = err_q;
    assign chk_cnt = chk_q;

endmodule

// File: tb/tb_dff_resp_checker.sv
// Bench for dff_resp_checker: two instances (1-bit/latency 1, 8-bit/latency 3 with 4-bit counters)
// against a run-length/stimulus-log reference model.
module tb_dff_resp_checker;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int CW_A  = 16;
    localparam int CW_B  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       stim_a = 1'b0;
    logic       resp_a = 1'b0;
    logic [7:0] stim_b = 8'h00;
    logic [7:0] resp_b = 8'h00;

    logic            busy_o [2];
    logic            fail_o [2];
    logic [CW_A-1:0] err_a, chk_a;
    logic [CW_B-1:0] err_b, chk_b;
    int              err_o [2];
    int              chk_o [2];

    always #5 clk = ~clk;

    dff_resp_checker #(.WIDTH(1), .LATENCY(LAT_A), .CNT_W(CW_A)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .stim(stim_a), .resp(resp_a),
        .busy(busy_o[0]), .fail(fail_o[0]), .err_cnt(err_a), .chk_cnt(chk_a)
    );

    dff_resp_checker #(.WIDTH(8), .LATENCY(LAT_B), .CNT_W(CW_B)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .stim(stim_b), .resp(resp_b),
        .busy(busy_o[1]), .fail(fail_o[1]), .err_cnt(err_b), .chk_cnt(chk_b)
    );

    always_comb begin
        err_o[0] = int'(err_a);
        chk_o[0] = int'(chk_a);
        err_o[1] = int'(err_b);
        chk_o[1] = int'(chk_b);
    end

    // Reference model: a compare happens on the k-th consecutive en edge when k > LATENCY,
    // against the stimulus logged LATENCY en-edges earlier.
    int         m_run  [2];
    int         m_chk  [2];
    int         m_err  [2];
    logic       m_fail [2];
    logic       m_busy [2];
    logic       m_halt [2];
    logic [7:0] elog   [2][4096];
    int         m_n    [2] = '{0, 0};

    // Emulated d->q paths feeding resp: stim delayed by LATENCY clocks, every clock.
    logic       pipe_a = 1'b0;
    logic [7:0] pipe_b [3] = '{8'h00, 8'h00, 8'h00};

    int n_checks = 0;
    int n_errors = 0;

    function automatic int lat(input int m);
        return (m == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int cmax(input int m);
        return (m == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1);
    endfunction

    task automatic model_edge(input int m, input logic r, input logic e,
                              input logic [7:0] s, input logic [7:0] rs);
        if (r) begin
            m_run[m] = 0; m_chk[m] = 0; m_err[m] = 0;
            m_fail[m] = 1'b0; m_busy[m] = 1'b0; m_halt[m] = 1'b0;
        end else if (m_halt[m]) begin
            m_busy[m] = 1'b0;
        end else if (!e) begin
            m_run[m]  = 0;
            m_busy[m] = 1'b0;
        end else begin
            m_run[m]++;
            if (m_run[m] > lat(m)) begin
                if (m_chk[m] < cmax(m)) m_chk[m]++;
                if (rs !== elog[m][(m_n[m] - lat(m)) % 4096]) begin
                    if (m_err[m] < cmax(m)) m_err[m]++;
                    m_fail[m] = 1'b1;
`ifdef DFF_RESP_CHECKER_HALT_EN
                    m_halt[m] = 1'b1;
`endif
                end
            end
            elog[m][m_n[m] % 4096] = s;
            m_n[m]++;
            m_busy[m] = !m_halt[m];
        end
    endtask

    // One clock: drive at negedge, model at posedge, outputs sampled 1 time unit later.
    task automatic step(input logic r, input logic e, input logic sa, input logic [7:0] sb,
                        input logic xa, input logic [7:0] xb);
        @(negedge clk);
        rst    = r;
        en     = e;
        stim_a = sa;
        stim_b = sb;
        resp_a = pipe_a ^ xa;
        resp_b = pipe_b[2] ^ xb;
        @(posedge clk);
        model_edge(0, r, e, {7'b0, sa}, {7'b0, resp_a});
        model_edge(1, r, e, sb, resp_b);
        pipe_a    = sa;
        pipe_b[2] = pipe_b[1];
        pipe_b[1] = pipe_b[0];
        pipe_b[0] = sb;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (busy_o[m] !== 1'b0) begin n_errors++; $display("FAIL reset dut%0d busy: got %0b want 0", m, busy_o[m]); end
            n_checks++;
            if (fail_o[m] !== 1'b0) begin n_errors++; $display("FAIL reset dut%0d fail: got %0b want 0", m, fail_o[m]); end
            n_checks++;
            if (err_o[m] !== 0) begin n_errors++; $display("FAIL reset dut%0d err_cnt: got %0d want 0", m, err_o[m]); end
            n_checks++;
            if (chk_o[m] !== 0) begin n_errors++; $display("FAIL reset dut%0d chk_cnt: got %0d want 0", m, chk_o[m]); end
        end
    endtask

    task automatic test_clean_fill();
        logic       sa_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] sb_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, sa_tab[i], sb_tab[i], 1'b0, 8'h00);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (busy_o[m] !== 1'b1) begin n_errors++; $display("FAIL clean dut%0d edge%0d busy: got %0b want 1", m, i + 1, busy_o[m]); end
                n_checks++;
                if (err_o[m] !== 0 || fail_o[m] !== 1'b0) begin n_errors++; $display("FAIL clean dut%0d edge%0d err/fail: got %0d/%0b want 0/0", m, i + 1, err_o[m], fail_o[m]); end
            end
            n_checks++;
            if (chk_o[0] !== i) begin n_errors++; $display("FAIL clean lat1 edge%0d chk_cnt: got %0d want %0d", i + 1, chk_o[0], i); end
            n_checks++;
            if (chk_o[1] !== ((i == 3) ? 1 : 0)) begin n_errors++; $display("FAIL clean lat3 edge%0d chk_cnt: got %0d want %0d", i + 1, chk_o[1], (i == 3) ? 1 : 0); end
        end
    endtask

    task automatic test_lat1_mismatch();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'($urandom), (i == 2), 8'h00);
            if (i >= 2) begin
                n_checks++;
                if (fail_o[0] !== 1'b1 || err_o[0] !== 1) begin n_errors++; $display("FAIL lat1_mm edge%0d fail/err: got %0b/%0d want 1/1", i + 1, fail_o[0], err_o[0]); end
                n_checks++;
                if (chk_o[0] !== m_chk[0]) begin n_errors++; $display("FAIL lat1_mm edge%0d chk_cnt: got %0d want %0d", i + 1, chk_o[0], m_chk[0]); end
                n_checks++;
                if (busy_o[0] !== m_busy[0]) begin n_errors++; $display("FAIL lat1_mm edge%0d busy: got %0b want %0b", i + 1, busy_o[0], m_busy[0]); end
            end
            n_checks++;
            if (err_o[1] !== 0 || fail_o[1] !== 1'b0) begin n_errors++; $display("FAIL lat1_mm lat3 edge%0d err/fail: got %0d/%0b want 0/0", i + 1, err_o[1], fail_o[1]); end
        end
        n_checks++;
        if (chk_o[1] !== 3) begin n_errors++; $display("FAIL lat1_mm lat3 chk_cnt: got %0d want 3", chk_o[1]); end
    endtask

    task automatic test_saturation();
        int exp_err;
        int exp_chk;
`ifdef DFF_RESP_CHECKER_HALT_EN
        exp_err = 1;
        exp_chk = 1;
`else
        exp_err = 15;
        exp_chk = 15;
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 8'($urandom), 1'b0, 8'hff);
            n_checks++;
            if (err_o[1] !== m_err[1] || chk_o[1] !== m_chk[1]) begin n_errors++; $display("FAIL sat edge%0d err/chk: got %0d/%0d want %0d/%0d", i + 1, err_o[1], chk_o[1], m_err[1], m_chk[1]); end
        end
        n_checks++;
        if (err_o[1] !== exp_err || chk_o[1] !== exp_chk || fail_o[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL sat final err/chk/fail: got %0d/%0d/%0b want %0d/%0d/1", err_o[1], chk_o[1], fail_o[1], exp_err, exp_chk);
        end
    endtask

    task automatic test_reset_mid_check();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 8'($urandom), (i == 2 || i == 3), 8'h00);
        end
        n_checks++;
        if (err_o[0] !== m_err[0] || fail_o[0] !== 1'b1) begin n_errors++; $display("FAIL rst_mid pre err/fail: got %0d/%0b want %0d/1", err_o[0], fail_o[0], m_err[0]); end
        step(1'b1, 1'b1, 1'b1, 8'h5a, 1'b0, 8'h00);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (busy_o[m] !== 1'b0 || fail_o[m] !== 1'b0 || err_o[m] !== 0 || chk_o[m] !== 0) begin
                n_errors++;
                $display("FAIL rst_mid dut%0d busy/fail/err/chk: got %0b/%0b/%0d/%0d want 0/0/0/0", m, busy_o[m], fail_o[m], err_o[m], chk_o[m]);
            end
        end
        step(1'b0, 1'b1, 1'b1, 8'h5a, 1'b0, 8'h00);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (busy_o[m] !== 1'b1 || chk_o[m] !== 0) begin n_errors++; $display("FAIL rst_mid dut%0d refill busy/chk: got %0b/%0d want 1/0", m, busy_o[m], chk_o[m]); end
        end
    endtask

    task automatic test_en_drop();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'($urandom), 8'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 8'($urandom), 1'b0, 8'h00);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (busy_o[m] !== 1'b0 || chk_o[m] !== m_chk[m]) begin n_errors++; $display("FAIL en_drop dut%0d idle busy/chk: got %0b/%0d want 0/%0d", m, busy_o[m], chk_o[m], m_chk[m]); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 8'($urandom), 1'b0, 8'h00);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (busy_o[m] !== m_busy[m] || chk_o[m] !== m_chk[m] || err_o[m] !== m_err[m]) begin
                    n_errors++;
                    $display("FAIL en_drop dut%0d rearm%0d busy/chk/err: got %0b/%0d/%0d want %0b/%0d/%0d", m, i, busy_o[m], chk_o[m], err_o[m], m_busy[m], m_chk[m], m_err[m]);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic exp_busy;
        int   exp_err;
        int   exp_chk;
`ifdef DFF_RESP_CHECKER_HALT_EN
        exp_busy = 1'b0; exp_err = 1;  exp_chk = 5;
`else
        exp_busy = 1'b1; exp_err = 11; exp_chk = 15;
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 8'($urandom), (i >= 5), 8'h00);
            n_checks++;
            if (busy_o[0] !== m_busy[0] || err_o[0] !== m_err[0] || chk_o[0] !== m_chk[0]) begin
                n_errors++;
                $display("FAIL halt edge%0d busy/err/chk: got %0b/%0d/%0d want %0b/%0d/%0d", i + 1, busy_o[0], err_o[0], chk_o[0], m_busy[0], m_err[0], m_chk[0]);
            end
        end
        n_checks++;
        if (busy_o[0] !== exp_busy || err_o[0] !== exp_err || chk_o[0] !== exp_chk) begin
            n_errors++;
            $display("FAIL halt final busy/err/chk: got %0b/%0d/%0d want %0b/%0d/%0d", busy_o[0], err_o[0], chk_o[0], exp_busy, exp_err, exp_chk);
        end
    endtask

    task automatic test_random();
        logic       r, e, xa;
        logic [7:0] xb;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) != 0);
            xa = ($urandom_range(0, 9) == 0);
            xb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            step(r, e, 1'($urandom), 8'($urandom), xa, xb);
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (busy_o[m] !== m_busy[m]) begin n_errors++; $display("FAIL rnd%0d dut%0d busy: got %0b want %0b", i, m, busy_o[m], m_busy[m]); end
                n_checks++;
                if (fail_o[m] !== m_fail[m]) begin n_errors++; $display("FAIL rnd%0d dut%0d fail: got %0b want %0b", i, m, fail_o[m], m_fail[m]); end
                n_checks++;
                if (err_o[m] !== m_err[m]) begin n_errors++; $display("FAIL rnd%0d dut%0d err_cnt: got %0d want %0d", i, m, err_o[m], m_err[m]); end
                n_checks++;
                if (chk_o[m] !== m_chk[m]) begin n_errors++; $display("FAIL rnd%0d dut%0d chk_cnt: got %0d want %0d", i, m, chk_o[m], m_chk[m]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_fill();
        test_lat1_mismatch();
        test_saturation();
        test_reset_mid_check();
        test_en_drop();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
